rr_arb4: RTL and testbench

RR_ARB4 -- requirements
Module: rr_arb4

---
 rtl/rr_arb4.sv | 106 ++++++++++
 tb/tb_rr_arb4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter with a bounded hold time.
// A grant is held while its requester keeps req high, up to MAXHOLD cycles.
// Every grant release is followed by a one-cycle GAP before the next
// arbitration, and the rotating pointer then puts the last owner at the
// end of the search order.
module rr_arb4 #(
  parameter int MAXHOLD = 15
) (
  input  logic       ck,
  input  logic       nrst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gid,
  output logic       busy,
  output logic       tout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] MAXHOLD_C = 4'(MAXHOLD);

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [3:0] cnt_r;
  logic [1:0] win_s;
  logic [1:0] cand_s;
  logic       found_s;

  // Winner search: first high request starting at ptr_r and wrapping round.
  always_comb begin
    win_s   = 2'd0;
    cand_s  = 2'd0;
    found_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand_s = ptr_r + 2'(i);
      if (!found_s && req[cand_s]) begin
        win_s   = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Arbitration state machine; every output is a register updated here.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      cnt_r   <= 4'd0;
      gnt     <= 4'd0;
      gid     <= 2'd0;
      busy    <= 1'b0;
      tout    <= 1'b0;
    end else begin
      // tout is a single-cycle pulse unless the timeout branch sets it
      tout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            gnt     <= 4'b0001 << win_s;
            gid     <= win_s;
            busy    <= 1'b1;
            cnt_r   <= 4'd1;
            state_r <= GRANT;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (!req[gid]) begin
            // owner released voluntarily
            gnt     <= 4'd0;
            busy    <= 1'b0;
            ptr_r   <= gid + 2'd1;
            state_r <= GAP;
          end else if (cnt_r >= MAXHOLD_C) begin
            // owner held too long: revoke and flag it
            gnt     <= 4'd0;
            busy    <= 1'b0;
            tout    <= 1'b1;
            ptr_r   <= gid + 2'd1;
            state_r <= GAP;
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            state_r <= GRANT;
          end
        end
        GAP: begin
          // dead cycle: requests are deliberately not looked at here
          state_r <= IDLE;
        end
        default: begin
          gnt     <= 4'd0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// tb_rr_arb4: random and directed stimulus for rr_arb4, compared every cycle
// against a transaction-level model of the arbitration rules.
module tb_rr_arb4;

  localparam int MAXHOLD = 15;

  logic       ck;
  logic       nrst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gid;
  logic       busy;
  logic       tout;

  int n_checks;
  int n_fail;

  // model state: who owns the resource, for how long, and where search starts
  int m_owner;
  int m_held;
  int m_gap;
  int m_ptr;
  int m_last;
  int m_tout;

  logic [3:0] prev_gnt;
  logic [3:0] samp_req;

  rr_arb4 #(.MAXHOLD(MAXHOLD)) dut (
    .ck   (ck),
    .nrst (nrst),
    .req  (req),
    .gnt  (gnt),
    .gid  (gid),
    .busy (busy),
    .tout (tout)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_held   = 0;
    m_gap    = 0;
    m_ptr    = 0;
    m_last   = 0;
    m_tout   = 0;
    prev_gnt = 4'd0;
  endtask

  // One rising edge of the arbitration rules, given the sampled requests.
  task automatic model_edge(input logic [3:0] r);
    m_tout = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || m_held == MAXHOLD) begin
        m_tout  = r[m_owner] ? 1 : 0;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap != 0) begin
      m_gap = 0;
    end else if (r != 4'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % 4]) m_owner = (m_ptr + i) % 4;
      end
      m_held = 1;
      m_last = m_owner;
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'd0;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("gid", 32'(gid), 32'(m_last));
    check_eq("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    check_eq("tout", 32'(tout), 32'(m_tout));
    check_eq("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (gnt != 4'd0 && prev_gnt == 4'd0)
      check_eq("gnt_vs_req", 32'(gnt & samp_req), 32'(gnt));
    prev_gnt = gnt;
  endtask

  task automatic step();
    @(posedge ck);
    samp_req = req;
    model_edge(samp_req);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    req  = 4'd0;
    #3;
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_gid", 32'(gid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tout", 32'(tout), 32'd0);
    @(negedge ck);
    nrst = 1'b1;
    model_reset();
  endtask

  initial begin
    int exp_order[5];
    int g;
    int lows;
    int n;
    int hi;
    n_checks = 0;
    n_fail   = 0;
    samp_req = 4'd0;
    model_reset();

    // reset state, then a basic grant
    do_reset();
    req = 4'b1010;
    step();
    check_eq("basic_gnt", 32'(gnt), 32'h2);
    check_eq("basic_gid", 32'(gid), 32'd1);
    check_eq("basic_busy", 32'(busy), 32'd1);

    // rotation with each owner releasing after 3 cycles
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'hF;
    step();
    for (int k = 0; k < 5; k++) begin
      check_eq("rot_gid", 32'(gid), 32'(exp_order[k]));
      check_eq("rot_gnt", 32'(gnt), 32'(4'b0001 << exp_order[k]));
      g = int'(gid);
      step();
      step();
      req[g] = 1'b0;
      step();
      check_eq("rot_drop", 32'(gnt), 32'd0);
      lows = 1;
      req  = 4'hF;
      n    = 0;
      while (gnt == 4'd0 && n < 20) begin
        step();
        n++;
        if (gnt == 4'd0) lows++;
      end
      check_eq("rot_lows", 32'(lows), 32'd2);
    end

    // single requester held forever: timeout after MAXHOLD cycles
    do_reset();
    req = 4'b0001;
    step();
    hi = 1;
    while (gnt != 4'd0 && hi < 40) begin
      step();
      if (gnt != 4'd0) hi++;
    end
    check_eq("to_hold", 32'(hi), 32'(MAXHOLD));
    check_eq("to_pulse", 32'(tout), 32'd1);
    step();
    check_eq("to_pulse_end", 32'(tout), 32'd0);
    check_eq("to_gap", 32'(gnt), 32'd0);
    step();
    check_eq("to_regrant", 32'(gnt), 32'h1);

    // timeout of requester 2 hands over to requester 0
    do_reset();
    req = 4'b0100;
    step();
    check_eq("t2_gid", 32'(gid), 32'd2);
    req = 4'b0101;
    n = 0;
    while (gnt != 4'd0 && n < 40) begin
      step();
      n++;
    end
    check_eq("t2_tout", 32'(tout), 32'd1);
    step();
    step();
    check_eq("t2_next_gid", 32'(gid), 32'd0);
    check_eq("t2_next_gnt", 32'(gnt), 32'h1);

    // asynchronous reset pulse in the middle of a grant
    do_reset();
    req = 4'b1000;
    step();
    step();
    check_eq("ar_pre", 32'(gnt), 32'h8);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("ar_gnt", 32'(gnt), 32'd0);
    check_eq("ar_busy", 32'(busy), 32'd0);
    check_eq("ar_tout", 32'(tout), 32'd0);
    nrst = 1'b1;
    model_reset();
    req = 4'hF;
    step();
    check_eq("ar_next_gid", 32'(gid), 32'd0);
    check_eq("ar_next_gnt", 32'(gnt), 32'h1);

    // random traffic, mostly steady requests so holds and timeouts occur
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
